// File: rtl/srt4_seq_divider.sv
// ============================================================================
// Module   : srt4_seq_divider
// Purpose  : Iterative radix-4 SRT unsigned divider (digits -3..3, on-the-fly
//            quotient conversion, correction cycle, optional round-half-up).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module srt4_seq_divider #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             round_nearest,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             rounded_up,
    output logic             div_by_zero
);

    localparam int ITER = (WIDTH + 1) / 2;
    localparam int PW   = 2 * ITER;
    localparam int RW   = WIDTH + 3;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_n;
    logic [WIDTH-1:0] r_d;
    logic            r_round;
    logic [RW-1:0]   r_r;      // two's-complement partial remainder
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qm;    // always r_q - 1 (mod 2^WIDTH)
    logic [CW-1:0]   r_count;

    logic            w_accept;
    logic [RW-1:0]   w_w;
    logic            w_neg;
    logic [RW-1:0]   w_abs;
    logic [RW-1:0]   w_d1;
    logic [RW-1:0]   w_d2;
    logic [RW-1:0]   w_d3;
    logic [1:0]      w_mag;
    logic [RW-1:0]   w_mult;
    logic [RW-1:0]   w_r_nxt;
    logic            w_q_nonneg;
    logic            w_q_pos;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_qm_nxt;
    logic            w_r_is_neg;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic            w_round_up;

    assign w_accept = in_valid && (r_state == S_IDLE);

    // Shifted remainder plus the next dividend digit pair; |w| < 4D by invariant.
    assign w_w   = {r_r[RW-3:0], 2'b00} + {{(RW-2){1'b0}}, r_n[PW-1 -: 2]};
    assign w_neg = w_w[RW-1];
    assign w_abs = w_neg ? (~w_w + RW'(1)) : w_w;
    assign w_d1  = {3'b000, r_d};
    assign w_d2  = {2'b00, r_d, 1'b0};
    assign w_d3  = w_d1 + w_d2;

    always_comb begin
        w_mag  = 2'd0;
        w_mult = '0;
        if (w_abs >= w_d3) begin
            w_mag  = 2'd3;
            w_mult = w_d3;
        end else if (w_abs >= w_d2) begin
            w_mag  = 2'd2;
            w_mult = w_d2;
        end else if (w_abs >= w_d1) begin
            w_mag  = 2'd1;
            w_mult = w_d1;
        end
    end

    assign w_r_nxt    = w_neg ? (w_w + w_mult) : (w_w - w_mult);
    assign w_q_nonneg = !w_neg || (w_mag == 2'd0);
    assign w_q_pos    = !w_neg && (w_mag != 2'd0);

    // On-the-fly conversion: negative digits borrow from QM instead of propagating.
    assign w_q_nxt  = w_q_nonneg ? {r_q[WIDTH-3:0], w_mag}
                                 : {r_qm[WIDTH-3:0], 2'b00 - w_mag};
    assign w_qm_nxt = w_q_pos    ? {r_q[WIDTH-3:0], w_mag - 2'd1}
                                 : {r_qm[WIDTH-3:0], 2'd3 - w_mag};

    assign w_r_is_neg = r_r[RW-1];
    assign w_rem_fix  = w_r_is_neg ? (r_r[WIDTH-1:0] + r_d) : r_r[WIDTH-1:0];
    assign w_quo_fix  = w_r_is_neg ? r_qm : r_q;
    assign w_round_up = r_round && ({w_rem_fix, 1'b0} >= {1'b0, r_d});

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_state_nxt = (divisor == '0) ? S_DONE : S_ITER;
            end
            S_ITER: begin
                if (r_count == CW'(ITER - 1))
                    w_state_nxt = S_FIX;
            end
            S_FIX: w_state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_d         <= '0;
            r_round     <= 1'b0;
            r_r         <= '0;
            r_q         <= '0;
            r_qm        <= '0;
            r_count     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            rounded_up  <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_n         <= PW'(dividend);
                        r_d         <= divisor;
                        r_round     <= round_nearest;
                        r_r         <= '0;
                        r_q         <= '0;
                        r_qm        <= '1;
                        r_count     <= '0;
                        rounded_up  <= 1'b0;
                        div_by_zero <= (divisor == '0);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                S_ITER: begin
                    r_r     <= w_r_nxt;
                    r_q     <= w_q_nxt;
                    r_qm    <= w_qm_nxt;
                    r_n     <= {r_n[PW-3:0], 2'b00};
                    r_count <= r_count + CW'(1);
                end
                S_FIX: begin
                    quotient   <= w_quo_fix + WIDTH'(w_round_up);
                    remainder  <= w_rem_fix;
                    rounded_up <= w_round_up;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_srt4_seq_divider.sv
// Self-checking bench for srt4_seq_divider at WIDTH=24 and WIDTH=7,
// compared against plain floor-division arithmetic.
`default_nettype none

module tb_srt4_seq_divider;

    localparam int WA = 24;
    localparam int WB = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_in_valid = 1'b0, a_in_ready, a_round = 1'b0;
    logic          a_out_valid, a_out_ready = 1'b0, a_ru, a_dz;
    logic [WA-1:0] a_n = '0, a_d = '0, a_q, a_r;

    logic          b_in_valid = 1'b0, b_in_ready, b_round = 1'b0;
    logic          b_out_valid, b_out_ready = 1'b0, b_ru, b_dz;
    logic [WB-1:0] b_n = '0, b_d = '0, b_q, b_r;

    int n_vec = 0;
    int n_err = 0;

    srt4_seq_divider #(.WIDTH(WA)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .dividend(a_n), .divisor(a_d), .round_nearest(a_round),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .quotient(a_q),
        .remainder(a_r), .rounded_up(a_ru), .div_by_zero(a_dz)
    );

    srt4_seq_divider #(.WIDTH(WB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .dividend(b_n), .divisor(b_d), .round_nearest(b_round),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .quotient(b_q),
        .remainder(b_r), .rounded_up(b_ru), .div_by_zero(b_dz)
    );

    // Reference: floor division, round half-up, all-ones quotient on D=0.
    function automatic void model(input int w, input longint unsigned n, input longint unsigned d,
                                  input logic rnd, output longint unsigned q,
                                  output longint unsigned r, output logic ru, output logic dz);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        if (d == 0) begin
            q = mask; r = n; ru = 1'b0; dz = 1'b1;
        end else begin
            q = n / d; r = n % d; dz = 1'b0;
            ru = rnd && (2 * r >= d);
            if (ru) q = q + 1;
        end
    endfunction

    function automatic logic [31:0] rand_val(input int w);
        int k;
        k = $urandom_range(w, 1);
        return $urandom & ((32'd1 << k) - 32'd1);
    endfunction

    task automatic start_a(input logic [WA-1:0] n, input logic [WA-1:0] d, input logic rnd);
        int k = 0;
        while (!a_in_ready && k < 60) begin @(posedge clk); #1; k++; end
        if (!a_in_ready) begin
            n_err++;
            $display("FAIL start_a in_ready timeout: got %b want 1", a_in_ready);
        end
        a_n = n; a_d = d; a_round = rnd; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic wait_a(output int lat);
        lat = 1;
        while (!a_out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic pop_a();
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({a_in_ready, a_out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_hs_a: got ready/valid %b want 10", {a_in_ready, a_out_valid});
        end
        n_vec++;
        if ({a_q, a_r, a_ru, a_dz} !== '0) begin
            n_err++;
            $display("FAIL reset_out_a: got q=%h r=%h ru=%b dz=%b want all 0", a_q, a_r, a_ru, a_dz);
        end
        n_vec++;
        if ({b_in_ready, b_out_valid, b_q, b_r, b_ru, b_dz} !== {2'b10, {(2*WB+2){1'b0}}}) begin
            n_err++;
            $display("FAIL reset_b: got rdy=%b vld=%b q=%h r=%h", b_in_ready, b_out_valid, b_q, b_r);
        end
    endtask

    logic [WA-1:0] dir_n   [7] = '{24'd100, 24'd100, 24'd100, 24'hFFFFFF, 24'hFFFFFF, 24'd5,      24'd7};
    logic [WA-1:0] dir_d   [7] = '{24'd7,   24'd8,   24'd7,   24'd1,      24'hFFFFFF, 24'd0,      24'd2};
    logic          dir_rnd [7] = '{1'b0,    1'b1,    1'b1,    1'b0,       1'b0,       1'b0,       1'b1};
    logic [WA-1:0] dir_q   [7] = '{24'd14,  24'd13,  24'd14,  24'hFFFFFF, 24'd1,      24'hFFFFFF, 24'd4};
    logic [WA-1:0] dir_r   [7] = '{24'd2,   24'd4,   24'd2,   24'd0,      24'd0,      24'd5,      24'd1};
    logic          dir_ru  [7] = '{1'b0,    1'b1,    1'b0,    1'b0,       1'b0,       1'b0,       1'b1};
    logic          dir_dz  [7] = '{1'b0,    1'b0,    1'b0,    1'b0,       1'b0,       1'b1,       1'b0};
    int            dir_lat [7] = '{14,      14,      14,      14,         14,         1,          14};

    task automatic test_directed();
        int lat;
        for (int i = 0; i < 7; i++) begin
            start_a(dir_n[i], dir_d[i], dir_rnd[i]);
            wait_a(lat);
            n_vec++;
            if (!a_out_valid || lat != dir_lat[i]) begin
                n_err++;
                $display("FAIL directed_latency[%0d]: got %0d (valid=%b) want %0d", i, lat, a_out_valid, dir_lat[i]);
            end
            n_vec++;
            if ({a_q, a_r, a_ru, a_dz} !== {dir_q[i], dir_r[i], dir_ru[i], dir_dz[i]}) begin
                n_err++;
                $display("FAIL directed_result[%0d]: got q=%h r=%h ru=%b dz=%b want q=%h r=%h ru=%b dz=%b",
                         i, a_q, a_r, a_ru, a_dz, dir_q[i], dir_r[i], dir_ru[i], dir_dz[i]);
            end
            pop_a();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        longint unsigned eq, er;
        logic eru, edz;
        logic [WA-1:0] vq, vr;
        model(WA, 1234, 56, 1'b1, eq, er, eru, edz);
        vq = eq[WA-1:0]; vr = er[WA-1:0];
        start_a(24'd1234, 24'd56, 1'b1);
        wait_a(lat);
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if ({a_out_valid, a_in_ready, a_q, a_r, a_ru, a_dz} !== {2'b10, vq, vr, eru, edz}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b q=%h r=%h want vld=1 rdy=0 q=%h r=%h",
                         c, a_out_valid, a_in_ready, a_q, a_r, vq, vr);
            end
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        a_n = 24'd200; a_d = 24'd9; a_round = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        n_vec++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_idle: got vld/rdy %b want 01", {a_out_valid, a_in_ready});
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n_vec++;
        if (a_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: got in_ready %b want 0", a_in_ready);
        end
        wait_a(lat);
        n_vec++;
        if ({a_out_valid, a_q, a_r} !== {1'b1, 24'd22, 24'd2} || lat != 14) begin
            n_err++;
            $display("FAIL b2b_result: got vld=%b q=%0d r=%0d lat=%0d want 1 22 2 14", a_out_valid, a_q, a_r, lat);
        end
        pop_a();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        start_a(24'd50000, 24'd7, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL midreset_hs: got vld/rdy %b want 01", {a_out_valid, a_in_ready});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (a_out_valid) seen++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL midreset_stale: got %0d valid cycles want 0", seen);
        end
        start_a(24'd1000, 24'd3, 1'b0);
        wait_a(lat);
        n_vec++;
        if ({a_out_valid, a_q, a_r, a_dz} !== {1'b1, 24'd333, 24'd1, 1'b0} || lat != 14) begin
            n_err++;
            $display("FAIL midreset_next: got vld=%b q=%0d r=%0d lat=%0d want 1 333 1 14", a_out_valid, a_q, a_r, lat);
        end
        pop_a();
    endtask

    task automatic test_random_a(input int count);
        int lat, elat;
        longint unsigned eq, er;
        logic eru, edz;
        logic [WA-1:0] n, d, vq, vr;
        logic rnd;
        for (int i = 0; i < count; i++) begin
            n = WA'(rand_val(WA));
            d = (($urandom & 63) == 0) ? '0 : WA'(rand_val(WA));
            rnd = 1'($urandom);
            model(WA, n, d, rnd, eq, er, eru, edz);
            vq = eq[WA-1:0]; vr = er[WA-1:0];
            elat = (d == 0) ? 1 : 14;
            start_a(n, d, rnd);
            wait_a(lat);
            n_vec++;
            if ({a_out_valid, a_q, a_r, a_ru, a_dz} !== {1'b1, vq, vr, eru, edz} || lat != elat) begin
                n_err++;
                $display("FAIL rand24 N=%h D=%h rnd=%b: got q=%h r=%h ru=%b dz=%b lat=%0d want q=%h r=%h ru=%b dz=%b lat=%0d",
                         n, d, rnd, a_q, a_r, a_ru, a_dz, lat, vq, vr, eru, edz, elat);
            end
            pop_a();
        end
    endtask

    task automatic test_random_b(input int count);
        int lat, k;
        longint unsigned eq, er;
        logic eru, edz;
        logic [WB-1:0] vq, vr;
        for (int i = 0; i < count; i++) begin
            k = 0;
            while (!b_in_ready && k < 60) begin @(posedge clk); #1; k++; end
            b_n = WB'(rand_val(WB));
            b_d = (($urandom & 31) == 0) ? '0 : WB'(rand_val(WB));
            b_round = 1'($urandom);
            model(WB, b_n, b_d, b_round, eq, er, eru, edz);
            vq = eq[WB-1:0]; vr = er[WB-1:0];
            b_in_valid = 1'b1;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            lat = 1;
            while (!b_out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
            n_vec++;
            if ({b_out_valid, b_q, b_r, b_ru, b_dz} !== {1'b1, vq, vr, eru, edz} || lat != ((b_d == 0) ? 1 : 6)) begin
                n_err++;
                $display("FAIL rand7 N=%h D=%h rnd=%b: got q=%h r=%h ru=%b dz=%b lat=%0d want q=%h r=%h ru=%b dz=%b",
                         b_n, b_d, b_round, b_q, b_r, b_ru, b_dz, lat, vq, vr, eru, edz);
            end
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random_a(2500);
        test_random_b(3000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
